i2c_master_sequencer: RTL and testbench

- Byte-level transaction controller for the I2C master path.
- On a start request it issues an ordered stream of bus commands (START, address bytes, data bytes, repeated START, STOP) to the master byte/bit engine.
- Moves data between the TX/RX FIFOs and that engine, handles 7- and 10-bit addressing, and reports ACK errors and completion.
- Sits beside the slave core in the I2C peripheral and shares the same FIFOs and status flags.

---
 rtl/i2c_master_pkg.sv | 36 +++
 rtl/i2c_master_byte_counter.sv | 30 +++
 rtl/i2c_master_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_master_sequencer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared definitions for the I2C master transaction sequencer: byte-engine
// command codes, sequencer states and address-byte formatting.
package i2c_master_pkg;

   localparam logic [2:0] CMD_NONE   = 3'd0;
   localparam logic [2:0] CMD_START  = 3'd1;
   localparam logic [2:0] CMD_RSTART = 3'd2;
   localparam logic [2:0] CMD_WRITE  = 3'd3;
   localparam logic [2:0] CMD_READ   = 3'd4;
   localparam logic [2:0] CMD_STOP   = 3'd5;

   localparam logic [4:0] TEN_BIT_HDR = 5'b11110;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR_HI,
      ADDR_LO,
      RSTART,
      ADDR_RD,
      WAIT_TX,
      WRITE,
      WAIT_RX,
      READ,
      STOP
   } state_t;

   // First address byte on the bus; in 10-bit mode the direction bit is
   // always write here, the read header goes out after the repeated START.
   function automatic logic [7:0] addr_hi_byte(input logic       ten_bit,
                                               input logic [9:0] addr,
                                               input logic       rw);
      return ten_bit ? {TEN_BIT_HDR, addr[9:8], 1'b0} : {addr[6:0], rw};
   endfunction

endpackage

// File: rtl/i2c_master_byte_counter.sv
// Remaining-data-byte counter for the master sequencer: parallel load,
// saturating decrement, zero and last-byte flags.
module i2c_master_byte_counter #(
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [COUNT_WIDTH-1:0] load_value,
   input  logic                   decrement,
   output logic                   zero,
   output logic                   last
);

   logic [COUNT_WIDTH-1:0] remaining;

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
      end else if (load) begin
         remaining <= load_value;
      end else if (decrement && (remaining != '0)) begin
         remaining <= remaining - 1'b1;
      end
   end

   assign zero = (remaining == '0);
   assign last = (remaining == COUNT_WIDTH'(1));

endmodule

// File: rtl/i2c_master_sequencer.sv
// I2C master transaction sequencer: turns one start request into the ordered
// START / address / data / STOP command stream for the master byte engine.
module i2c_master_sequencer
   import i2c_master_pkg::*;
#(
   parameter int unsigned COUNT_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_request,
   input  logic                   rw_mode,
   input  logic                   address_mode,
   input  logic [9:0]             bus_address,
   input  logic [COUNT_WIDTH-1:0] data_count,
   input  logic                   TX_fifo_empty,
   input  logic [7:0]             tx_data,
   input  logic                   RX_fifo_full,
   output logic [2:0]             cmd,
   output logic [7:0]             cmd_data,
   output logic                   cmd_nack,
   output logic                   cmd_valid,
   input  logic                   cmd_done,
   input  logic                   ack_received,
   input  logic [7:0]             rx_byte,
   output logic                   TX_read_enable_master,
   output logic                   RX_write_enable_master,
   output logic [7:0]             rx_data_master,
   output logic                   busy_master,
   output logic                   ack_error_set_master,
   output logic                   set_transaction_complete_master
);

   state_t     state;
   logic       rw_q;
   logic       ten_q;
   logic [9:0] addr_q;

   logic cnt_load;
   logic cnt_dec;
   logic cnt_zero;
   logic cnt_last;

   always_comb begin
      cnt_load = (state == IDLE) && start_request;
      cnt_dec  = cmd_valid && cmd_done &&
                 ((state == READ) || ((state == WRITE) && ack_received));
   end

   i2c_master_byte_counter #(
      .COUNT_WIDTH(COUNT_WIDTH)
   ) u_byte_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .load_value(data_count),
      .decrement (cnt_dec),
      .zero      (cnt_zero),
      .last      (cnt_last)
   );

   // A zero byte count turns the transaction into an address probe.
   function automatic state_t data_phase(input logic none_left, input logic rd);
      if (none_left) begin
         return STOP;
      end
      return rd ? WAIT_RX : WAIT_TX;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state                           <= IDLE;
         rw_q                            <= 1'b0;
         ten_q                           <= 1'b0;
         addr_q                          <= '0;
         cmd                             <= CMD_NONE;
         cmd_data                        <= '0;
         cmd_nack                        <= 1'b0;
         cmd_valid                       <= 1'b0;
         TX_read_enable_master           <= 1'b0;
         RX_write_enable_master          <= 1'b0;
         rx_data_master                  <= '0;
         busy_master                     <= 1'b0;
         ack_error_set_master            <= 1'b0;
         set_transaction_complete_master <= 1'b0;
      end else begin
         TX_read_enable_master           <= 1'b0;
         RX_write_enable_master          <= 1'b0;
         ack_error_set_master            <= 1'b0;
         set_transaction_complete_master <= 1'b0;

         // Retiring a command is common to every command state; each state
         // below only issues its command and picks the successor on cmd_done.
         if (cmd_valid && cmd_done) begin
            cmd_valid <= 1'b0;
            cmd       <= CMD_NONE;
            cmd_nack  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start_request) begin
                  rw_q        <= rw_mode;
                  ten_q       <= address_mode;
                  addr_q      <= bus_address;
                  busy_master <= 1'b1;
                  state       <= START;
               end
            end
            START: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_START;
               end else if (cmd_done) begin
                  state <= ADDR_HI;
               end
            end
            ADDR_HI: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_WRITE;
                  cmd_data  <= addr_hi_byte(ten_q, addr_q, rw_q);
               end else if (cmd_done) begin
                  if (!ack_received) begin
                     ack_error_set_master <= 1'b1;
                     state                <= STOP;
                  end else if (ten_q) begin
                     state <= ADDR_LO;
                  end else begin
                     state <= data_phase(cnt_zero, rw_q);
                  end
               end
            end
            ADDR_LO: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_WRITE;
                  cmd_data  <= addr_q[7:0];
               end else if (cmd_done) begin
                  if (!ack_received) begin
                     ack_error_set_master <= 1'b1;
                     state                <= STOP;
                  end else if (rw_q) begin
                     state <= RSTART;
                  end else begin
                     state <= data_phase(cnt_zero, 1'b0);
                  end
               end
            end
            RSTART: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_RSTART;
               end else if (cmd_done) begin
                  state <= ADDR_RD;
               end
            end
            ADDR_RD: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_WRITE;
                  cmd_data  <= {TEN_BIT_HDR, addr_q[9:8], 1'b1};
               end else if (cmd_done) begin
                  if (!ack_received) begin
                     ack_error_set_master <= 1'b1;
                     state                <= STOP;
                  end else begin
                     state <= data_phase(cnt_zero, 1'b1);
                  end
               end
            end
            WAIT_TX: begin
               if (!TX_fifo_empty) begin
                  TX_read_enable_master <= 1'b1;
                  cmd_data              <= tx_data;
                  state                 <= WRITE;
               end
            end
            WRITE: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_WRITE;
               end else if (cmd_done) begin
                  if (!ack_received) begin
                     ack_error_set_master <= 1'b1;
                     state                <= STOP;
                  end else begin
                     state <= cnt_last ? STOP : WAIT_TX;
                  end
               end
            end
            WAIT_RX: begin
               if (!RX_fifo_full) begin
                  state <= READ;
               end
            end
            READ: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_READ;
                  cmd_nack  <= cnt_last;
               end else if (cmd_done) begin
                  rx_data_master         <= rx_byte;
                  RX_write_enable_master <= 1'b1;
                  state                  <= cnt_last ? STOP : WAIT_RX;
               end
            end
            STOP: begin
               if (!cmd_valid) begin
                  cmd_valid <= 1'b1;
                  cmd       <= CMD_STOP;
               end else if (cmd_done) begin
                  set_transaction_complete_master <= 1'b1;
                  busy_master                     <= 1'b0;
                  state                           <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Bench for i2c_master_sequencer: byte-engine and FIFO models plus a
// transaction-level reference of the expected command stream.
module tb_i2c_master_sequencer;
   import i2c_master_pkg::*;

   typedef logic [7:0] byte_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_request = 1'b0;
   logic        rw_mode = 1'b0;
   logic        address_mode = 1'b0;
   logic [9:0]  bus_address = '0;
   logic [7:0]  data_count = '0;
   logic        TX_fifo_empty;
   logic [7:0]  tx_data;
   logic        RX_fifo_full = 1'b0;
   logic [2:0]  cmd;
   logic [7:0]  cmd_data;
   logic        cmd_nack;
   logic        cmd_valid;
   logic        cmd_done;
   logic        ack_received;
   logic [7:0]  rx_byte;
   logic        TX_read_enable_master;
   logic        RX_write_enable_master;
   logic [7:0]  rx_data_master;
   logic        busy_master;
   logic        ack_error_set_master;
   logic        set_transaction_complete_master;

   always #5 clk = ~clk;

   i2c_master_sequencer #(
      .COUNT_WIDTH(8)
   ) dut (
      .clk                            (clk),
      .rst                            (rst),
      .start_request                  (start_request),
      .rw_mode                        (rw_mode),
      .address_mode                   (address_mode),
      .bus_address                    (bus_address),
      .data_count                     (data_count),
      .TX_fifo_empty                  (TX_fifo_empty),
      .tx_data                        (tx_data),
      .RX_fifo_full                   (RX_fifo_full),
      .cmd                            (cmd),
      .cmd_data                       (cmd_data),
      .cmd_nack                       (cmd_nack),
      .cmd_valid                      (cmd_valid),
      .cmd_done                       (cmd_done),
      .ack_received                   (ack_received),
      .rx_byte                        (rx_byte),
      .TX_read_enable_master          (TX_read_enable_master),
      .RX_write_enable_master         (RX_write_enable_master),
      .rx_data_master                 (rx_data_master),
      .busy_master                    (busy_master),
      .ack_error_set_master           (ack_error_set_master),
      .set_transaction_complete_master(set_transaction_complete_master)
   );

   int total = 0;
   int bad   = 0;

   // Owned by the test process.
   int          txn_seq  = 0;
   byte_t       tx_load[$];
   byte_t       rx_load[$];
   int          nack_at  = -1;
   logic        tx_stall = 1'b0;
   logic [11:0] exp_cmds[$];
   byte_t       exp_push[$];
   int          exp_pops;
   int          exp_errs;

   // Owned by the engine/FIFO/monitor process.
   int          seen_seq = 0;
   logic [11:0] obs[$];
   byte_t       tx_q[$];
   byte_t       rx_src[$];
   byte_t       pushes[$];
   int          pops = 0, errs = 0, comps = 0, proto_err = 0;
   int          widx = 0, eng_wait = 0;
   bit          pending = 0, drove_done = 0, valid_at_done = 0, prev_valid = 0;
   logic [2:0]  pend_cmd;
   logic [11:0] prev_bits;

   // Command entry {code, data, nack}; data only matters for WRITE, nack only for READ.
   function automatic logic [11:0] ent(input logic [2:0] c, input logic [7:0] d, input logic k);
      return {c, (c == CMD_WRITE) ? d : 8'h00, (c == CMD_READ) ? k : 1'b0};
   endfunction

   function automatic logic [25:0] out_vec();
      return {cmd, cmd_data, cmd_nack, cmd_valid, TX_read_enable_master, RX_write_enable_master,
              rx_data_master, busy_master, ack_error_set_master, set_transaction_complete_master};
   endfunction

   initial begin
      byte_t junk;
      cmd_done = 1'b0; ack_received = 1'b0; rx_byte = '0;
      TX_fifo_empty = 1'b1; tx_data = '0;
      forever begin
         @(negedge clk);
         if (txn_seq != seen_seq) begin
            seen_seq = txn_seq;
            obs.delete(); pushes.delete();
            tx_q = tx_load; rx_src = rx_load;
            pops = 0; errs = 0; comps = 0; proto_err = 0; widx = 0; pending = 0;
         end
         if (cmd_valid && prev_valid && ({cmd, cmd_data, cmd_nack} != prev_bits)) proto_err++;
         if (drove_done && valid_at_done && cmd_valid) proto_err++;
         if (set_transaction_complete_master) begin
            comps++;
            if (busy_master) proto_err++;
         end
         if (ack_error_set_master) errs++;
         if (RX_write_enable_master) pushes.push_back(rx_data_master);
         if (TX_read_enable_master) begin
            pops++;
            if (tx_q.size() == 0) proto_err++;
            else junk = tx_q.pop_front();
         end
         valid_at_done = cmd_valid;
         drove_done    = 1'b0;
         cmd_done      = 1'b0;
         if (rst) begin
            pending = 0;
         end else if (pending) begin
            if (eng_wait == 0) begin
               cmd_done = 1'b1; drove_done = 1'b1; pending = 0;
               ack_received = $urandom_range(0, 1);
               rx_byte      = 8'($urandom);
               if (pend_cmd == CMD_WRITE) begin
                  ack_received = (widx != nack_at);
                  widx++;
               end
               if (pend_cmd == CMD_READ && rx_src.size() != 0) rx_byte = rx_src.pop_front();
            end else begin
               eng_wait--;
            end
         end else if (cmd_valid) begin
            obs.push_back(ent(cmd, cmd_data, cmd_nack));
            pending  = 1;
            pend_cmd = cmd;
            eng_wait = $urandom_range(0, 3);
         end
         TX_fifo_empty = tx_stall || (tx_q.size() == 0);
         tx_data       = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
         prev_valid    = cmd_valid;
         prev_bits     = {cmd, cmd_data, cmd_nack};
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Reference: the command stream a transaction must produce, from the protocol rules.
   task automatic build_expect(input bit rw, input bit ten, input logic [9:0] a,
                               input int n, input int nk);
      logic [11:0] hdr[$];
      int w;
      bit dead;
      exp_cmds.delete(); exp_push.delete();
      exp_pops = 0; w = 0; dead = 0;
      exp_cmds.push_back(ent(CMD_START, 8'h00, 1'b0));
      if (!ten) begin
         hdr.push_back(ent(CMD_WRITE, {a[6:0], rw}, 1'b0));
      end else begin
         hdr.push_back(ent(CMD_WRITE, {5'b11110, a[9:8], 1'b0}, 1'b0));
         hdr.push_back(ent(CMD_WRITE, a[7:0], 1'b0));
         if (rw) begin
            hdr.push_back(ent(CMD_RSTART, 8'h00, 1'b0));
            hdr.push_back(ent(CMD_WRITE, {5'b11110, a[9:8], 1'b1}, 1'b0));
         end
      end
      foreach (hdr[i]) begin
         if (!dead) begin
            exp_cmds.push_back(hdr[i]);
            if (hdr[i][11:9] == CMD_WRITE) begin
               dead = (w == nk);
               w++;
            end
         end
      end
      for (int i = 0; i < n && !dead; i++) begin
         if (!rw) begin
            exp_cmds.push_back(ent(CMD_WRITE, tx_load[i], 1'b0));
            exp_pops++;
            dead = (w == nk);
            w++;
         end else begin
            exp_cmds.push_back(ent(CMD_READ, 8'h00, i == n - 1));
            exp_push.push_back(rx_load[i]);
         end
      end
      exp_cmds.push_back(ent(CMD_STOP, 8'h00, 1'b0));
      exp_errs = dead ? 1 : 0;
   endtask

   task automatic launch(input bit rw, input bit ten, input logic [9:0] a,
                         input int n, input int nk);
      nack_at = nk;
      txn_seq++;
      tick();
      rw_mode = rw; address_mode = ten; bus_address = a; data_count = 8'(n);
      start_request = 1'b1;
      tick();
      start_request = 1'b0;
      rw_mode = 1'($urandom); address_mode = 1'($urandom);
      bus_address = 10'($urandom); data_count = 8'($urandom);
   endtask

   task automatic wait_complete(input int budget, output bit ok);
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (comps > 0) begin
            ok = 1;
            break;
         end
      end
      repeat (3) tick();
   endtask

   task automatic wait_obs(input int n);
      for (int i = 0; i < 400 && obs.size() < n; i++) tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start_request = 1'b1;
      repeat (3) tick();
      total++;
      if (out_vec() !== 26'h0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0", out_vec());
      end
      rst = 1'b0; start_request = 1'b0;
      repeat (4) tick();
      total++;
      if (busy_master !== 1'b0 || cmd_valid !== 1'b0) begin
         bad++; $display("FAIL rst_beats_start: busy=%b cmd_valid=%b want 0 0", busy_master, cmd_valid);
      end
   endtask

   task automatic test_txn_table();
      for (int t = 0; t < 24; t++) begin
         bit rw, ten, ok;
         logic [9:0] a;
         int n, nk;
         logic [11:0] got;
         tx_load.delete(); rx_load.delete();
         case (t)
            0: begin rw = 0; ten = 0; a = 10'h050; n = 2; nk = -1; tx_load = '{8'hA5, 8'h3C}; end
            1: begin rw = 1; ten = 0; a = 10'h050; n = 3; nk = -1; rx_load = '{8'h11, 8'h22, 8'h33}; end
            2: begin rw = 1; ten = 1; a = 10'h2F3; n = 1; nk = -1; rx_load = '{8'h9C}; end
            3: begin rw = 0; ten = 0; a = 10'h050; n = 2; nk = 0;  tx_load = '{8'h12, 8'h34}; end
            default: begin
               rw = 1'($urandom); ten = 1'($urandom); a = 10'($urandom);
               n = $urandom_range(0, 5);
               nk = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1;
               for (int i = 0; i <= n; i++) begin
                  tx_load.push_back(8'($urandom));
                  rx_load.push_back(8'($urandom));
               end
            end
         endcase
         build_expect(rw, ten, a, n, nk);
         launch(rw, ten, a, n, nk);
         wait_complete(600, ok);
         total++;
         if (!ok) begin bad++; $display("FAIL txn%0d_timeout: no complete pulse within budget", t); end
         total++;
         if (obs.size() != exp_cmds.size()) begin
            bad++; $display("FAIL txn%0d_cmd_count: got %0d want %0d", t, obs.size(), exp_cmds.size());
         end
         for (int i = 0; i < exp_cmds.size(); i++) begin
            got = (i < obs.size()) ? obs[i] : 12'hFFF;
            total++;
            if (got !== exp_cmds[i]) begin
               bad++; $display("FAIL txn%0d_cmd%0d: got %h want %h", t, i, got, exp_cmds[i]);
            end
         end
         total++;
         if (pops != exp_pops) begin bad++; $display("FAIL txn%0d_tx_pops: got %0d want %0d", t, pops, exp_pops); end
         total++;
         if (pushes != exp_push) begin
            bad++; $display("FAIL txn%0d_rx_pushes: got %0d bytes want %0d bytes (or data differs)", t, pushes.size(), exp_push.size());
         end
         total++;
         if (errs != exp_errs) begin bad++; $display("FAIL txn%0d_ack_error: got %0d want %0d", t, errs, exp_errs); end
         total++;
         if (comps != 1) begin bad++; $display("FAIL txn%0d_complete: got %0d want 1", t, comps); end
         total++;
         if (busy_master !== 1'b0) begin bad++; $display("FAIL txn%0d_busy_after: got %b want 0", t, busy_master); end
         total++;
         if (proto_err != 0) begin bad++; $display("FAIL txn%0d_handshake: got %0d violations want 0", t, proto_err); end
      end
   endtask

   task automatic test_tx_stall();
      int stall_bad = 0;
      int seen;
      bit ok;
      tx_stall = 1'b1;
      tx_load = '{8'h5A}; rx_load.delete();
      build_expect(0, 0, 10'h050, 1, -1);
      launch(0, 0, 10'h050, 1, -1);
      wait_obs(2);
      repeat (8) tick();
      repeat (10) begin
         tick();
         if (cmd_valid || TX_read_enable_master || pops != 0) stall_bad++;
      end
      seen = obs.size();
      tx_stall = 1'b0;
      wait_complete(300, ok);
      total++;
      if (stall_bad != 0 || seen != 2) begin
         bad++; $display("FAIL tx_stall_quiet: got %0d busy cycles, %0d cmds want 0, 2", stall_bad, seen);
      end
      total++;
      if (obs != exp_cmds) begin bad++; $display("FAIL tx_stall_cmds: got %0d cmds want %0d (or content differs)", obs.size(), exp_cmds.size()); end
      total++;
      if (pops != 1 || comps != 1 || !ok) begin
         bad++; $display("FAIL tx_stall_end: pops=%0d complete=%0d want 1 1", pops, comps);
      end
   endtask

   task automatic test_rx_stall();
      int stall_bad = 0;
      int seen;
      bit ok;
      RX_fifo_full = 1'b1;
      tx_load.delete(); rx_load = '{8'hC1, 8'hC2};
      build_expect(1, 0, 10'h033, 2, -1);
      launch(1, 0, 10'h033, 2, -1);
      wait_obs(2);
      repeat (8) tick();
      repeat (10) begin
         tick();
         if (cmd_valid) stall_bad++;
      end
      seen = obs.size();
      RX_fifo_full = 1'b0;
      wait_complete(300, ok);
      total++;
      if (stall_bad != 0 || seen != 2) begin
         bad++; $display("FAIL rx_stall_quiet: got %0d busy cycles, %0d cmds want 0, 2", stall_bad, seen);
      end
      total++;
      if (obs != exp_cmds) begin bad++; $display("FAIL rx_stall_cmds: got %0d cmds want %0d (or content differs)", obs.size(), exp_cmds.size()); end
      total++;
      if (pushes != exp_push || comps != 1 || !ok) begin
         bad++; $display("FAIL rx_stall_end: pushes=%0d complete=%0d want 2 1", pushes.size(), comps);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      tx_load = '{8'h01, 8'h02, 8'h03}; rx_load.delete();
      launch(0, 0, 10'h021, 3, -1);
      wait_obs(3);
      rst = 1'b1;
      tick();
      total++;
      if (out_vec() !== 26'h0) begin
         bad++; $display("FAIL reset_mid_outputs: got %h want 0", out_vec());
      end
      tick();
      rst = 1'b0;
      tick();
      tx_load = '{8'h77};
      build_expect(0, 1, 10'h3A5, 1, -1);
      launch(0, 1, 10'h3A5, 1, -1);
      wait_complete(300, ok);
      total++;
      if (obs != exp_cmds || !ok) begin
         bad++; $display("FAIL reset_mid_rerun_cmds: got %0d cmds want %0d (or content differs)", obs.size(), exp_cmds.size());
      end
      total++;
      if (pops != 1 || comps != 1 || proto_err != 0) begin
         bad++; $display("FAIL reset_mid_rerun_end: pops=%0d complete=%0d handshake=%0d want 1 1 0", pops, comps, proto_err);
      end
   endtask

   initial begin
      test_reset();
      test_txn_table();
      test_tx_stall();
      test_rx_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
